// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the SRAM port arbiter and its requesters/SRAM pads.
// slave = arbiter side, master = requesters and SRAM pad side.
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_ack;
   logic              clr_req;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] clr_wdata;
   logic              clr_ack;
   logic              stp_req;
   logic              stp_we;
   logic [ADDR_W-1:0] stp_addr;
   logic [DATA_W-1:0] stp_wdata;
   logic              stp_ack;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] Data_from_SRAM;
   logic [DATA_W-1:0] Data_to_SRAM;
   logic              dq_oe;
   logic [ADDR_W-1:0] SRAM_ADDRESS;
   logic              SRAM_WE_N;
   logic              SRAM_OE_N;
   logic              busy;

   modport slave (
      input  vga_req, vga_addr,
      input  clr_req, clr_addr, clr_wdata,
      input  stp_req, stp_we, stp_addr, stp_wdata,
      input  Data_from_SRAM,
      output vga_ack, clr_ack, stp_ack, rdata,
      output Data_to_SRAM, dq_oe, SRAM_ADDRESS,
      output SRAM_WE_N, SRAM_OE_N, busy
   );

   modport master (
      output vga_req, vga_addr,
      output clr_req, clr_addr, clr_wdata,
      output stp_req, stp_we, stp_addr, stp_wdata,
      output Data_from_SRAM,
      input  vga_ack, clr_ack, stp_ack, rdata,
      input  Data_to_SRAM, dq_oe, SRAM_ADDRESS,
      input  SRAM_WE_N, SRAM_OE_N, busy
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between VGA, clear and step engines.
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate clear/step fairly.
module sram_port_arbiter #(
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 16,
   parameter int STROBE_CYCLES = 2
) (
   input logic               Clk,
   input logic               Reset,
   sram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, SETUP, STROBE, RECOVER
   } state_t;

   typedef enum logic [1:0] {
      OWN_VGA, OWN_CLR, OWN_STP
   } owner_t;

   localparam logic [3:0] CNT_LOAD =
      4'(STROBE_CYCLES - 1);

   state_t            state_q, state_d;
   owner_t            own_q, own_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic              dq_q, dq_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;
   logic              busy_q, busy_d;
   logic [2:0]        ack_q, ack_d;
   logic              gnt_vga, gnt_clr, gnt_stp;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   // ptr 0 favours clear, 1 favours step
   logic ptr_q, ptr_d;

   // Pick the winner; clear/step ties go by pointer
   always_comb begin
      gnt_vga = bus.vga_req;
      gnt_clr = !bus.vga_req && bus.clr_req &&
                (!bus.stp_req || !ptr_q);
      gnt_stp = !bus.vga_req && bus.stp_req &&
                (!bus.clr_req || ptr_q);
      ptr_d   = ptr_q;
      if (state_q == IDLE) begin
         if (gnt_clr) ptr_d = 1'b1;
         if (gnt_stp) ptr_d = 1'b0;
      end
   end

   // Fairness pointer register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end
`else
   // Pick the winner by fixed priority
   always_comb begin
      gnt_vga = bus.vga_req;
      gnt_clr = !bus.vga_req && bus.clr_req;
      gnt_stp = !bus.vga_req && !bus.clr_req &&
                bus.stp_req;
   end
`endif

   // Next state and next registered outputs
   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      rd_d    = rd_q;
      dq_d    = dq_q;
      we_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      busy_d  = busy_q;
      ack_d   = 3'b000;
      unique case (state_q)
         IDLE: begin
            unique case (1'b1)
               gnt_vga: begin
                  own_d  = OWN_VGA;
                  we_d   = 1'b0;
                  addr_d = bus.vga_addr;
               end
               gnt_clr: begin
                  own_d  = OWN_CLR;
                  we_d   = 1'b1;
                  addr_d = bus.clr_addr;
                  wd_d   = bus.clr_wdata;
               end
               gnt_stp: begin
                  own_d  = OWN_STP;
                  we_d   = bus.stp_we;
                  addr_d = bus.stp_addr;
                  wd_d   = bus.stp_wdata;
               end
               default: ;
            endcase
            if (gnt_vga || gnt_clr || gnt_stp) begin
               state_d = SETUP;
               busy_d  = 1'b1;
               dq_d    = we_d;
            end
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = CNT_LOAD;
            we_n_d  = !we_q;
            oe_n_d  = we_q;
         end
         STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = RECOVER;
               if (!we_q) rd_d = bus.Data_from_SRAM;
               ack_d[own_q] = 1'b1;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               we_n_d = !we_q;
               oe_n_d = we_q;
            end
         end
         RECOVER: begin
            state_d = IDLE;
            dq_d    = 1'b0;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         own_q   <= OWN_VGA;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wd_q    <= '0;
         rd_q    <= '0;
         dq_q    <= 1'b0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         ack_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
         dq_q    <= dq_d;
         we_n_q  <= we_n_d;
         oe_n_q  <= oe_n_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.SRAM_ADDRESS = addr_q;
   assign bus.Data_to_SRAM = wd_q;
   assign bus.dq_oe        = dq_q;
   assign bus.SRAM_WE_N    = we_n_q;
   assign bus.SRAM_OE_N    = oe_n_q;
   assign bus.busy         = busy_q;
   assign bus.rdata        = rd_q;
   assign bus.vga_ack      = ack_q[OWN_VGA];
   assign bus.clr_ack      = ack_q[OWN_CLR];
   assign bus.stp_ack      = ack_q[OWN_STP];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, scoreboard of acks,
// and hand sequences for contention, fairness, abort and turnaround.
module tb_sram_port_arbiter;

   localparam int S = 2;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

   sram_port_arbiter #(
      .ADDR_W(20), .DATA_W(16), .STROBE_CYCLES(S)
   ) dut (
      .Clk(Clk), .Reset(Reset), .bus(bus)
   );

   typedef struct {
      logic [1:0]  own;
      logic [19:0] addr;
      logic [15:0] rd;
   } sb_t;

   typedef struct {
      logic [1:0]  who;
      logic        we;
      logic [19:0] addr;
      logic [15:0] wd;
      logic [15:0] sd;
      logic        early;
      logic [15:0] exp_rd;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   sb_t  sb[$];
   vec_t vt[6];

   function automatic void chk(string nm,
                               logic [31:0] act,
                               logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endfunction

   task automatic monitor();
      logic [2:0] a;
      logic [1:0] o;
      sb_t        e;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            a = {bus.stp_ack, bus.clr_ack, bus.vga_ack};
            chk("ack_overlap", 32'($countones(a) > 1), 0);
            chk("strobe_overlap",
                32'(!bus.SRAM_WE_N && !bus.SRAM_OE_N), 0);
            chk("oe_with_dq",
                32'(!bus.SRAM_OE_N && bus.dq_oe), 0);
            if (a != 3'b000) begin
               o = a[2] ? 2'd2 : (a[1] ? 2'd1 : 2'd0);
               if (sb.size() == 0) begin
                  chk("unexpected_ack", 32'(a), 0);
               end else begin
                  e = sb.pop_front();
                  chk("ack_owner", 32'(o), 32'(e.own));
                  chk("ack_addr", 32'(bus.SRAM_ADDRESS),
                      32'(e.addr));
                  chk("ack_rdata", 32'(bus.rdata), 32'(e.rd));
               end
            end
         end
      end
   endtask

   task automatic set_req(logic [1:0] who, logic v);
      case (who)
         2'd0:    bus.vga_req = v;
         2'd1:    bus.clr_req = v;
         default: bus.stp_req = v;
      endcase
   endtask

   task automatic run_vec(int i, vec_t v);
      logic [2:0] acks;
      @(posedge Clk); #1;
      bus.vga_addr  = v.addr;
      bus.clr_addr  = v.addr;
      bus.stp_addr  = v.addr;
      bus.clr_wdata = v.wd;
      bus.stp_wdata = v.wd;
      bus.stp_we    = v.we;
      set_req(v.who, 1'b1);
      sb.push_back('{own:v.who, addr:v.addr, rd:v.exp_rd});
      for (int k = 0; k <= S + 3; k++) begin
         @(negedge Clk);
         acks = {bus.stp_ack, bus.clr_ack, bus.vga_ack};
         if (k == 0)
            chk($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 0);
         if (k >= 1 && k <= S + 2) begin
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 1);
            chk($sformatf("v%0d_addr", i),
                32'(bus.SRAM_ADDRESS), 32'(v.addr));
            chk($sformatf("v%0d_dq_oe", i),
                32'(bus.dq_oe), 32'(v.we));
         end
         if (k == 1) begin
            chk($sformatf("v%0d_setup_we", i),
                32'(bus.SRAM_WE_N), 1);
            chk($sformatf("v%0d_setup_oe", i),
                32'(bus.SRAM_OE_N), 1);
            if (v.we)
               chk($sformatf("v%0d_wdata", i),
                   32'(bus.Data_to_SRAM), 32'(v.wd));
         end
         if (k >= 2 && k <= S + 1) begin
            chk($sformatf("v%0d_strobe_we", i),
                32'(bus.SRAM_WE_N), 32'(!v.we));
            chk($sformatf("v%0d_strobe_oe", i),
                32'(bus.SRAM_OE_N), 32'(v.we));
         end
         if (k == S + 2) begin
            chk($sformatf("v%0d_ack", i), 32'(acks),
                32'(3'b001 << v.who));
            chk($sformatf("v%0d_rdata", i),
                32'(bus.rdata), 32'(v.exp_rd));
            chk($sformatf("v%0d_rec_we", i),
                32'(bus.SRAM_WE_N), 1);
         end else begin
            chk($sformatf("v%0d_noack", i), 32'(acks), 0);
         end
         if (k == S + 3) begin
            chk($sformatf("v%0d_done_busy", i), 32'(bus.busy), 0);
            chk($sformatf("v%0d_done_dq", i), 32'(bus.dq_oe), 0);
         end
         bus.Data_from_SRAM = (k == S + 1) ? v.sd : ~v.sd;
         @(posedge Clk); #1;
         if ((v.early && k == 0) || k == S + 2)
            set_req(v.who, 1'b0);
      end
   endtask

   initial begin
      int vc, cc, sc, n;
      vt[0] = '{who:2'd0, we:1'b0, addr:20'h00123, wd:16'h0,
                sd:16'hBEEF, early:1'b0, exp_rd:16'hBEEF};
      vt[1] = '{who:2'd1, we:1'b1, addr:20'h40000, wd:16'h0000,
                sd:16'h1111, early:1'b0, exp_rd:16'hBEEF};
      vt[2] = '{who:2'd2, we:1'b0, addr:20'h00ABC, wd:16'h0,
                sd:16'h1234, early:1'b1, exp_rd:16'h1234};
      vt[3] = '{who:2'd2, we:1'b1, addr:20'hFFFFF, wd:16'hA5A5,
                sd:16'h2222, early:1'b1, exp_rd:16'h1234};
      vt[4] = '{who:2'd0, we:1'b0, addr:20'h7FFFF, wd:16'h0,
                sd:16'h0F0F, early:1'b0, exp_rd:16'h0F0F};
      vt[5] = '{who:2'd1, we:1'b1, addr:20'h00001, wd:16'hFFFF,
                sd:16'h3333, early:1'b1, exp_rd:16'h0F0F};

      bus.vga_req = 0; bus.clr_req = 0; bus.stp_req = 0;
      bus.stp_we = 0;
      bus.vga_addr = '0; bus.clr_addr = '0; bus.stp_addr = '0;
      bus.clr_wdata = '0; bus.stp_wdata = '0;
      bus.Data_from_SRAM = '0;

      #12;
      chk("rst_we_n", 32'(bus.SRAM_WE_N), 1);
      chk("rst_oe_n", 32'(bus.SRAM_OE_N), 1);
      chk("rst_addr", 32'(bus.SRAM_ADDRESS), 0);
      chk("rst_wdata", 32'(bus.Data_to_SRAM), 0);
      chk("rst_dq_oe", 32'(bus.dq_oe), 0);
      chk("rst_acks",
          32'({bus.vga_ack, bus.clr_ack, bus.stp_ack}), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      @(negedge Clk); #1 Reset = 1'b1;
      fork monitor(); join_none

      for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

      // all three at once; each drops req after its ack
      bus.Data_from_SRAM = 16'h5A5A;
      bus.vga_addr = 20'h10;
      bus.clr_addr = 20'h20; bus.clr_wdata = 16'h9999;
      bus.stp_addr = 20'h30; bus.stp_we = 1'b0;
      @(posedge Clk); #1;
      bus.vga_req = 1; bus.clr_req = 1; bus.stp_req = 1;
      sb.push_back('{own:2'd0, addr:20'h10, rd:16'h5A5A});
      sb.push_back('{own:2'd1, addr:20'h20, rd:16'h5A5A});
      sb.push_back('{own:2'd2, addr:20'h30, rd:16'h5A5A});
      vc = -1; cc = -1; sc = -1;
      for (int c = 0; c <= 16; c++) begin
         @(negedge Clk);
         if (bus.vga_ack) vc = c;
         if (bus.clr_ack) cc = c;
         if (bus.stp_ack) sc = c;
         @(posedge Clk); #1;
         if (vc == c) bus.vga_req = 0;
         if (cc == c) bus.clr_req = 0;
         if (sc == c) bus.stp_req = 0;
      end
      chk("all3_vga_cycle", 32'(vc), 4);
      chk("all3_clr_cycle", 32'(cc), 9);
      chk("all3_stp_cycle", 32'(sc), 14);
      chk("all3_sb_empty", 32'(sb.size()), 0);

      // clear and step both held for four accesses
      @(negedge Clk); #2 Reset = 1'b0;
      #1 Reset = 1'b1;
      chk("rr_rst_rdata", 32'(bus.rdata), 0);
      bus.clr_addr = 20'h111; bus.clr_wdata = 16'h6666;
      bus.stp_addr = 20'h222; bus.stp_wdata = 16'h7777;
      bus.stp_we = 1'b1;
      @(posedge Clk); #1;
      bus.clr_req = 1; bus.stp_req = 1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      sb.push_back('{own:2'd1, addr:20'h111, rd:16'h0});
      sb.push_back('{own:2'd2, addr:20'h222, rd:16'h0});
      sb.push_back('{own:2'd1, addr:20'h111, rd:16'h0});
      sb.push_back('{own:2'd2, addr:20'h222, rd:16'h0});
`else
      repeat (4)
         sb.push_back('{own:2'd1, addr:20'h111, rd:16'h0});
`endif
      n = 0;
      for (int c = 0; c < 4 * (S + 3) + 4 && n < 4; c++) begin
         @(negedge Clk);
         if (bus.clr_ack || bus.stp_ack) n++;
         @(posedge Clk); #1;
         if (n == 4) begin
            bus.clr_req = 0; bus.stp_req = 0;
         end
      end
      bus.clr_req = 0; bus.stp_req = 0;
      chk("rr_ack_count", 32'(n), 4);
      chk("rr_sb_empty", 32'(sb.size()), 0);
      repeat (S + 4) @(posedge Clk);

      // reset during STROBE of a clear write
      #1;
      bus.clr_addr = 20'h333; bus.clr_wdata = 16'h1357;
      bus.clr_req = 1;
      repeat (3) @(negedge Clk);
      chk("abort_pre_we_n", 32'(bus.SRAM_WE_N), 0);
      chk("abort_pre_dq", 32'(bus.dq_oe), 1);
      #2 Reset = 1'b0;
      #1;
      chk("abort_we_n", 32'(bus.SRAM_WE_N), 1);
      chk("abort_dq_oe", 32'(bus.dq_oe), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_ack", 32'(bus.clr_ack), 0);
      @(negedge Clk);
      chk("abort_ack_hold", 32'(bus.clr_ack), 0);
      #1 Reset = 1'b1;
      sb.push_back('{own:2'd1, addr:20'h333, rd:16'h0});
      for (int k = 1; k <= S + 2; k++) begin
         @(negedge Clk);
         if (k == 1) begin
            chk("restart_busy", 32'(bus.busy), 1);
            chk("restart_setup_we", 32'(bus.SRAM_WE_N), 1);
            chk("restart_dq", 32'(bus.dq_oe), 1);
         end
         chk($sformatf("restart_ack_k%0d", k),
             32'(bus.clr_ack), 32'(k == S + 2));
      end
      @(posedge Clk); #1 bus.clr_req = 0;

      // step read, then write with stp_we flipped after ack
      bus.Data_from_SRAM = 16'hC0DE;
      bus.stp_addr = 20'h444; bus.stp_we = 1'b0;
      @(posedge Clk); #1 bus.stp_req = 1;
      sb.push_back('{own:2'd2, addr:20'h444, rd:16'hC0DE});
      sb.push_back('{own:2'd2, addr:20'h445, rd:16'hC0DE});
      for (int c = 0; c <= 2 * S + 6; c++) begin
         @(negedge Clk);
         if (c == S + 2 || c == 2 * S + 5)
            chk($sformatf("b2b_ack_c%0d", c), 32'(bus.stp_ack), 1);
         if (c == S + 4) begin
            chk("b2b_wr_dq", 32'(bus.dq_oe), 1);
            chk("b2b_wr_data", 32'(bus.Data_to_SRAM), 16'h2468);
            chk("b2b_wr_addr", 32'(bus.SRAM_ADDRESS), 20'h445);
         end
         if (c >= S + 5 && c <= 2 * S + 4) begin
            chk("b2b_wr_we_n", 32'(bus.SRAM_WE_N), 0);
            chk("b2b_wr_oe_n", 32'(bus.SRAM_OE_N), 1);
         end
         @(posedge Clk); #1;
         if (c == S + 2) begin
            bus.stp_we = 1'b1; bus.stp_addr = 20'h445;
            bus.stp_wdata = 16'h2468;
         end
         if (c == 2 * S + 5) bus.stp_req = 0;
      end
      chk("b2b_sb_empty", 32'(sb.size()), 0);
      chk("b2b_rdata_held", 32'(bus.rdata), 16'hC0DE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
